uart_tx_frame_gen: RTL and testbench

Parametrised UART transmit framer. It captures a parallel word and serialises one complete frame onto TX_OUT, one bit per CLK cycle: start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, then 1 or 2 stop bits. It replaces the separate serializer, parity calculator, FSM and output-select arrangement with a single block. Word width, parity mode and stop-bit count are configurable. Sits between the UART TX data source (FIFO or synchroniser output) and the TX pin; CLK is the TX baud-rate clock.

---
 rtl/uart_tx_frame_gen_if.sv | 33 +++
 rtl/uart_tx_frame_gen.sv | 131 +++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-side bundle of the UART TX framer: word, request, frame options and the
// registered serial line / busy flag that the source watches.
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP_CFG;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output STOP_CFG,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  STOP_CFG,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB-first, optional parity,
// one or two stop bits, one bit per CLK. TX_OUT and Busy come straight from flops.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_frame_gen_if.slave tx_if
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  data_last;
    logic                  stop_last;

    assign accept    = (state_q == ST_IDLE) && tx_if.Data_Valid;
    assign data_last = (cnt_q == LAST_BIT);
    // The counter doubles as the stop-bit index; it is 0 on the first stop cycle.
    assign stop_last = (cnt_q == CNT_W'(stop2_q));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_if.Data_Valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (data_last) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (stop_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; the line level is chosen for the state being entered.
    always_comb begin
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;

        if (accept) begin
            data_d    = tx_if.P_DATA;
            par_en_d  = tx_if.PAR_EN;
            stop2_d   = tx_if.STOP_CFG;
            par_bit_d = (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
        end

        case (state_q)
            ST_DATA: begin
                cnt_d = data_last ? '0 : cnt_q + 1'b1;
            end
            ST_STOP: begin
                cnt_d = stop_last ? '0 : cnt_q + 1'b1;
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[cnt_d];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench for uart_tx_frame_gen: expected frames are queued at issue time and a
// negedge monitor compares every Busy cycle of TX_OUT against them, for 8- and 7-bit instances.
module tb_uart_tx_frame_gen;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic CLK;
    logic RST;

    int total;
    int bad;

    frame_t exp_q8[$];
    frame_t exp_q7[$];

    bit     mon_active [2];
    int     mon_idx    [2];
    frame_t mon_cur    [2];
    int     idle_run   [2];
    int     last_gap   [2];

    uart_tx_frame_gen_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_frame_gen_if #(.DATA_WIDTH(7)) if7 ();

    uart_tx_frame_gen #(.DATA_WIDTH(8)) dut8 (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (if8)
    );

    uart_tx_frame_gen #(.DATA_WIDTH(7)) dut7 (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (if7)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected bits are written in transmit order, first bit leftmost.
    task automatic applyStimulus(input int d, input logic [8:0] data, input logic pe, input logic pt,
                                 input logic sc, input logic [15:0] bits, input int len);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        if (d == 0) begin
            if8.P_DATA   = data[7:0];
            if8.PAR_EN   = pe;
            if8.PAR_TYP  = pt;
            if8.STOP_CFG = sc;
            if8.Data_Valid = 1'b1;
            exp_q8.push_back(f);
        end else begin
            if7.P_DATA   = data[6:0];
            if7.PAR_EN   = pe;
            if7.PAR_TYP  = pt;
            if7.STOP_CFG = sc;
            if7.Data_Valid = 1'b1;
            exp_q7.push_back(f);
        end
        @(posedge CLK);
        #1;
        if8.Data_Valid = 1'b0;
        if7.Data_Valid = 1'b0;
    endtask

    task automatic pushFrame(input int d, input logic [15:0] bits, input int len);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        if (d == 0) exp_q8.push_back(f);
        else        exp_q7.push_back(f);
    endtask

    task automatic waitDrain(input int d, input int budget);
        int qsize;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            qsize = (d == 0) ? exp_q8.size() : exp_q7.size();
            if (qsize == 0 && !mon_active[d]) return;
        end
        checkOutput($sformatf("dut%0d drain timeout", d), 16'(mon_active[d]), 16'd0);
    endtask

    task automatic monitorStep(input int d, input logic busy, input logic tx);
        frame_t f;
        int     qsize;
        if (mon_active[d]) begin
            if (mon_idx[d] < mon_cur[d].len) begin
                checkOutput($sformatf("dut%0d busy cycle %0d", d, mon_idx[d]), 16'(busy), 16'd1);
                checkOutput($sformatf("dut%0d tx cycle %0d", d, mon_idx[d]), 16'(tx),
                            16'(mon_cur[d].bits[mon_cur[d].len - 1 - mon_idx[d]]));
                mon_idx[d]++;
            end else begin
                checkOutput($sformatf("dut%0d busy after frame", d), 16'(busy), 16'd0);
                checkOutput($sformatf("dut%0d tx after frame", d), 16'(tx), 16'd1);
                mon_active[d] = 1'b0;
                idle_run[d]   = 1;
            end
        end else if (busy) begin
            qsize = (d == 0) ? exp_q8.size() : exp_q7.size();
            if (qsize == 0) begin
                checkOutput($sformatf("dut%0d unexpected frame busy", d), 16'(busy), 16'd0);
            end else begin
                f = (d == 0) ? exp_q8.pop_front() : exp_q7.pop_front();
                mon_cur[d]    = f;
                last_gap[d]   = idle_run[d];
                checkOutput($sformatf("dut%0d tx cycle 0", d), 16'(tx), 16'(f.bits[f.len - 1]));
                mon_idx[d]    = 1;
                mon_active[d] = 1'b1;
            end
        end else begin
            checkOutput($sformatf("dut%0d idle tx", d), 16'(tx), 16'd1);
            idle_run[d]++;
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            for (int k = 0; k < 2; k++) begin
                mon_active[k] = 1'b0;
                idle_run[k]   = 0;
            end
        end else begin
            monitorStep(0, if8.Busy, if8.TX_OUT);
            monitorStep(1, if7.Busy, if7.TX_OUT);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 2; k++) begin
            mon_active[k] = 1'b0;
            mon_idx[k]    = 0;
            idle_run[k]   = 0;
            last_gap[k]   = 0;
        end
        if8.P_DATA = '0; if8.Data_Valid = 1'b0; if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0; if8.STOP_CFG = 1'b0;
        if7.P_DATA = '0; if7.Data_Valid = 1'b0; if7.PAR_EN = 1'b0; if7.PAR_TYP = 1'b0; if7.STOP_CFG = 1'b0;

        RST = 1'b0;
        #23;
        checkOutput("reset tx8", 16'(if8.TX_OUT), 16'd1);
        checkOutput("reset busy8", 16'(if8.Busy), 16'd0);
        checkOutput("reset tx7", 16'(if7.TX_OUT), 16'd1);
        checkOutput("reset busy7", 16'(if7.Busy), 16'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] A5 even parity, one stop");
        applyStimulus(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'(11'b0_10100101_0_1), 11);
        waitDrain(0, 40);

        $display("[TB] A5 no parity");
        applyStimulus(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 16'(10'b0_10100101_1), 10);
        waitDrain(0, 40);

        $display("[TB] A5 odd parity, two stops");
        applyStimulus(0, 9'h0A5, 1'b1, 1'b1, 1'b1, 16'(12'b0_10100101_1_11), 12);
        waitDrain(0, 40);

        $display("[TB] back-to-back 00 then FF with Data_Valid held");
        if8.P_DATA = 8'h00; if8.PAR_EN = 1'b1; if8.PAR_TYP = 1'b0; if8.STOP_CFG = 1'b0;
        pushFrame(0, 16'(11'b0_00000000_0_1), 11);
        pushFrame(0, 16'(11'b0_11111111_0_1), 11);
        if8.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        if8.P_DATA = 8'hFF;
        begin : wait_idle
            for (int i = 0; i < 40; i++) begin
                @(posedge CLK);
                #1;
                if (!if8.Busy) disable wait_idle;
            end
        end
        @(posedge CLK);
        #1;
        if8.Data_Valid = 1'b0;
        waitDrain(0, 40);
        checkOutput("back-to-back idle gap", 16'(last_gap[0]), 16'd1);

        $display("[TB] Data_Valid pulse during a frame is ignored");
        applyStimulus(0, 9'h03C, 1'b1, 1'b0, 1'b0, 16'(11'b0_00111100_0_1), 11);
        repeat (3) @(posedge CLK);
        #1;
        if8.P_DATA = 8'hC3;
        if8.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        if8.Data_Valid = 1'b0;
        waitDrain(0, 40);
        repeat (6) @(posedge CLK);

        $display("[TB] option and data changes mid-frame");
        applyStimulus(0, 9'h096, 1'b1, 1'b1, 1'b0, 16'(11'b0_01101001_1_1), 11);
        repeat (2) @(posedge CLK);
        #1;
        if8.P_DATA = 8'h0F; if8.PAR_TYP = 1'b0; if8.STOP_CFG = 1'b1; if8.PAR_EN = 1'b0;
        waitDrain(0, 40);
        repeat (3) @(posedge CLK);
        #1;

        $display("[TB] reset during data bit 3");
        applyStimulus(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'(11'b0_10100101_0_1), 11);
        repeat (4) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async reset tx8", 16'(if8.TX_OUT), 16'd1);
        checkOutput("async reset busy8", 16'(if8.Busy), 16'd0);
        exp_q8.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        applyStimulus(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'(11'b0_10100101_0_1), 11);
        waitDrain(0, 40);

        $display("[TB] 7-bit 55 even parity");
        applyStimulus(1, 9'h055, 1'b1, 1'b0, 1'b0, 16'(10'b0_1010101_0_1), 10);
        waitDrain(1, 40);
        repeat (4) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
